// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receive framer.
// Recovers start/data/parity/stop frames from the serial line and hands each
// byte, with parity/framing/break/overrun flags, to the interface register
// file through a valid/ack handshake.
module uart_rx_frame #(
  parameter int unsigned OVS   = 16,
  parameter int unsigned DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br,
  input  logic             rx,
  input  logic             ideal_rx,
  input  logic [7:0]       lcr,
  input  logic             rv_ack,
  output logic [DBITS-1:0] rv_data,
  output logic             rv_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             brk,
  output logic             overrun
);

  localparam int unsigned CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned IDX_W = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DBITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity modes as seen in lcr[5:3]; bit 0 of the mode is the enable
  localparam logic [2:0] MODE_ODD  = 3'b001;
  localparam logic [2:0] MODE_ONE  = 3'b101;
  localparam logic [2:0] MODE_ZERO = 3'b111;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state,    state_d;
  logic [CNT_W-1:0] cnt,      cnt_d;
  logic [IDX_W-1:0] idx,      idx_d;
  logic [DBITS-1:0] shreg,    shreg_d;
  logic [2:0]       mode_q,   mode_d;
  logic             pbit_q,   pbit_d;
  logic             perr_q,   perr_d;
  logic             done_c;
  logic             par_err_c;
  logic [DBITS-1:0] rv_data_d;
  logic             rv_valid_d;
  logic             parity_err_d;
  logic             frame_err_d;
  logic             brk_d;
  logic             overrun_d;

  // Only the parity field of lcr is used here
  logic unused_lcr;
  assign unused_lcr = ^{lcr[7:6], lcr[2:0]};

  // Parity check of the sampled parity bit against the frame's latched mode
  always_comb begin
    par_err_c = (^shreg) ^ rx_s;
    case (mode_q)
      MODE_ODD:  par_err_c = ~((^shreg) ^ rx_s);
      MODE_ONE:  par_err_c = ~rx_s;
      MODE_ZERO: par_err_c = rx_s;
      default:   par_err_c = (^shreg) ^ rx_s;
    endcase
  end

  // Next-state, datapath and output/handshake logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    shreg_d      = shreg;
    mode_d       = mode_q;
    pbit_d       = pbit_q;
    perr_d       = perr_q;
    done_c       = 1'b0;
    rv_data_d    = rv_data;
    rv_valid_d   = rv_valid;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;
    brk_d        = brk;
    overrun_d    = overrun;

    if (ideal_rx) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (br) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
            mode_d  = lcr[5:3];
          end
        end
        S_START: begin
          if (cnt == CNT_MID) begin
            cnt_d   = '0;
            idx_d   = '0;
            pbit_d  = 1'b0;
            perr_d  = 1'b0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_END) begin
            cnt_d          = '0;
            shreg_d[idx]   = rx_s;
            if (idx == IDX_LAST) begin
              idx_d   = '0;
              state_d = mode_q[0] ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt == CNT_END) begin
            cnt_d   = '0;
            pbit_d  = rx_s;
            perr_d  = par_err_c;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_END) begin
            cnt_d   = '0;
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    if (done_c) begin
      rv_data_d    = shreg;
      rv_valid_d   = 1'b1;
      parity_err_d = perr_q;
      frame_err_d  = ~rx_s;
      brk_d        = (shreg == '0) & ~pbit_q & ~rx_s;
      overrun_d    = rv_valid & ~rv_ack;
    end else if (rv_ack && rv_valid) begin
      rv_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      brk_d        = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      mode_q     <= '0;
      pbit_q     <= 1'b0;
      perr_q     <= 1'b0;
      rv_data    <= '0;
      rv_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shreg      <= shreg_d;
      mode_q     <= mode_d;
      pbit_q     <= pbit_d;
      perr_q     <= perr_d;
      rv_data    <= rv_data_d;
      rv_valid   <= rv_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      brk        <= brk_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table of single frames plus
// hand-written sequences for glitch, overrun, coincident ack and aborts.
module tb_uart_rx_frame;

  localparam int unsigned BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

  logic       clk = 1'b0;
  logic       rst;
  logic       br;
  logic       rx;
  logic       ideal_rx;
  logic [7:0] lcr;
  logic       rv_ack;
  logic [7:0] rv_data;
  logic       rv_valid;
  logic       parity_err;
  logic       frame_err;
  logic       brk;
  logic       overrun;

  logic [31:0] cyc = 32'd0;
  int nchk  = 0;
  int npass = 0;
  int lat   = -1;

  uart_rx_frame #(.OVS(16), .DBITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .br         (br),
    .rx         (rx),
    .ideal_rx   (ideal_rx),
    .lcr        (lcr),
    .rv_ack     (rv_ack),
    .rv_data    (rv_data),
    .rv_valid   (rv_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .brk        (brk),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Sample tick: one clk high every four
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign br = (cyc[1:0] == 2'd0);

  typedef struct {
    logic [7:0] d;
    logic [7:0] l;
    logic       p;
    logic       stop;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic       e_brk;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic ack_pulse();
    @(negedge clk) rv_ack = 1'b1;
    @(negedge clk) rv_ack = 1'b0;
  endtask

  // Drive one frame aligned to the tick phase, followed by one idle bit time.
  // ack_at / abort_at are clk offsets from the start edge (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic [7:0] l, input logic p,
                            input logic stop, input int ack_at, input int abort_at,
                            input logic abort_rst, output int first_valid);
    logic bits [0:10];
    int   nb;
    int   bi;
    nb = l[3] ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9]    = p;
    bits[nb-1] = stop;
    lcr = l;
    @(negedge clk);
    while (cyc[1:0] != 2'd1) @(negedge clk);
    first_valid = -1;
    for (int t = 0; t < (nb + 1) * BIT_CLKS; t++) begin
      if (t > 0) @(negedge clk);
      if (first_valid < 0 && rv_valid) first_valid = t;
      bi       = t / BIT_CLKS;
      rx       = (bi < nb) ? bits[bi] : 1'b1;
      rv_ack   = (t == ack_at);
      ideal_rx = !abort_rst && (t == abort_at);
      rst      = abort_rst && (t == abort_at);
    end
    @(negedge clk);
    rx = 1'b1; rv_ack = 1'b0; ideal_rx = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int fv;
    vecs[0]  = '{8'h55, 8'h03, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hA3, 8'h1B, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'hA3, 8'h1B, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 8'h0B, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'hA3, 8'h0B, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h5A, 8'h2B, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h5A, 8'h3B, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h7E, 8'h03, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'h00, 8'h1B, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'h00, 8'h1B, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; rx = 1'b1; ideal_rx = 1'b0; lcr = 8'h03; rv_ack = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {rv_data, rv_valid, parity_err, frame_err, brk, overrun}, 32'd0);

    // Table of single frames, each acked a few cycles after completion
    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].d, vecs[i].l, vecs[i].p, vecs[i].stop, -1, -1, 1'b0, fv);
      if (i == 0) begin
        lat = fv;
        check("latency_window", 32'((fv >= 608) && (fv <= 618)), 32'd1);
      end
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(rv_valid), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(rv_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_flags", i), {29'd0, parity_err, frame_err, brk},
            {29'd0, vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_brk});
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
      ack_pulse();
      check($sformatf("vec%0d_after_ack", i),
            {27'd0, rv_valid, parity_err, frame_err, brk, overrun}, 32'd0);
    end

    // Short low glitch is rejected, then a clean frame is taken
    @(negedge clk);
    while (cyc[1:0] != 2'd1) @(negedge clk);
    rx = 1'b0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_valid", 32'(rv_valid), 32'd0);
    send_frame(8'h0F, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    check("after_glitch_valid", 32'(rv_valid), 32'd1);
    check("after_glitch_data", 32'(rv_data), 32'h0F);
    ack_pulse();

    // Two frames without ack: second overwrites, overrun set, ack clears
    send_frame(8'h11, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    send_frame(8'h22, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    check("ovr_data", 32'(rv_data), 32'h22);
    check("ovr_flag", {30'd0, rv_valid, overrun}, 32'd3);
    ack_pulse();
    check("ovr_cleared", {30'd0, rv_valid, overrun}, 32'd0);

    // Ack landing in the completion cycle of the second frame
    send_frame(8'h33, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    send_frame(8'h44, 8'h03, 1'b0, 1'b1, lat - 1, -1, 1'b0, fv);
    check("coinc_data", 32'(rv_data), 32'h44);
    check("coinc_valid_ovr", {30'd0, rv_valid, overrun}, 32'd2);
    ack_pulse();
    check("coinc_acked", 32'(rv_valid), 32'd0);

    // Receiver hold at data bit 4 keeps the pending byte and its flags
    send_frame(8'h99, 8'h03, 1'b0, 1'b0, -1, -1, 1'b0, fv);
    send_frame(8'hF3, 8'h03, 1'b0, 1'b1, -1, 340, 1'b0, fv);
    check("hold_kept_data", 32'(rv_data), 32'h99);
    check("hold_kept_flags", {28'd0, rv_valid, frame_err, brk, overrun}, 32'b1100);
    ack_pulse();
    send_frame(8'hC6, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    check("hold_next_data", 32'(rv_data), 32'hC6);
    check("hold_next_flags", {27'd0, rv_valid, parity_err, frame_err, brk, overrun}, 32'b10000);
    ack_pulse();

    // Reset at data bit 4 discards the partial byte and clears a pending one
    send_frame(8'h5A, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    send_frame(8'hF3, 8'h03, 1'b0, 1'b1, -1, 340, 1'b1, fv);
    check("rst_abort_outputs", {rv_data, rv_valid, parity_err, frame_err, brk, overrun}, 32'd0);
    send_frame(8'hC6, 8'h03, 1'b0, 1'b1, -1, -1, 1'b0, fv);
    check("rst_next_valid", 32'(rv_valid), 32'd1);
    check("rst_next_data", 32'(rv_data), 32'hC6);
    ack_pulse();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
16x-oversampled UART receive framer. It takes the serial `rx` line and the 16x sample tick from the baud generator, and recovers start/data/parity/stop frames. It delivers each received byte to the interface register file (RHR/LSR) together with error flags, using a valid/ack handshake. It sits directly upstream of the interface block's receive-data buffering and replaces its free-running sample capture with qualified, flagged bytes.

Parameters:
OVS, 16, sample ticks per bit; counter width is clog2(OVS); mid-bit sample point is OVS/2-1.
DBITS, 8, data bits per frame, LSB first.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
br  input  1  16x sample-enable tick, one clk cycle wide; the state machine advances only on ticks.
rx  input  1  asynchronous serial line; idle high.
ideal_rx  input  1  receiver hold; 1 = abort any frame and stay IDLE.
lcr  input  8  line control; lcr[3] = parity enable; lcr[5:3] parity mode: 001 odd, 011 even, 101 forced 1, 111 forced 0.
rv_ack  input  1  consumer accepts current byte (single-cycle pulse).
rv_data  output  8  received byte.
rv_valid  output  1  byte pending; held until acked.
parity_err  output  1  parity error for current byte.
frame_err  output  1  stop bit sampled low.
brk  output  1  break: data = 0, parity bit = 0 (if enabled), stop = 0.
overrun  output  1  sticky; a frame completed while the previous byte was unacked.

Behaviour:
- Reset: state IDLE; tick counter 0; bit index 0; both synchroniser flops 1; all outputs 0.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a br tick with rx_s = 0 and ideal_rx = 0, go to START, set cnt = 0, and latch lcr[5:3] for the whole frame.
- START: on each tick, cnt++. At cnt = OVS/2-1:
  - rx_s = 0: go to DATA, cnt = 0.
  - rx_s = 1: false start; return to IDLE with no output.
- DATA: on each tick, cnt++. At cnt = OVS-1:
  - shift rx_s into bit[idx], cnt = 0, idx++.
  - After bit DBITS-1: go to PARITY if the latched lcr[3] = 1, else go to STOP.
- PARITY: sample at cnt = OVS-1. The error condition depends on mode:
  - odd: error if XOR(data, p) = 0.
  - even: error if XOR(data, p) = 1.
  - forced 1: error if p = 0.
  - forced 0: error if p = 1.
  - Any other lcr[5:3] with lcr[3] = 1: treat as even.
- STOP: sample at cnt = OVS-1, which is the stop-bit midpoint. In the same clk cycle:
  - complete the frame.
  - return to IDLE.
  - the next start edge may be detected from the following tick.
- Frame completion, in one clk cycle:
  - rv_data <= shift register.
  - parity_err and frame_err <= computed values.
  - brk <= (data = 0) & (parity bit = 0 or parity disabled) & stop = 0. brk implies frame_err = 1.
  - rv_valid <= 1.
  - If rv_valid was already 1 and rv_ack = 0 this cycle: overrun <= 1 and the old byte is overwritten.
- Handshake:
  - rv_ack with rv_valid = 1 and no completion: rv_valid, parity_err, frame_err, brk and overrun all clear next cycle.
  - rv_ack in the same cycle as completion: the new byte is loaded, rv_valid stays 1, overrun is cleared and not set.
  - rv_ack with rv_valid = 0: ignored.
- Latency: rv_valid rises 1 clk after the stop-midpoint tick. For OVS = 16, 8N1, that is about 9.5 bit times after the start falling edge.
- ideal_rx = 1 in any state:
  - next clk: state IDLE, cnt = 0, idx = 0, shift register unchanged.
  - no completion occurs; pending rv_valid and flags are retained.
- rst mid-frame: all state and outputs return to reset values on the next clk; any partial byte is discarded.
- br inactive: state, cnt and outputs hold, except the handshake, which runs every clk.
- cnt wraps only under FSM control; it is never free-running in IDLE.

Test Plan:
- 8N1 (lcr = 0x03), send 0x55 at 16 ticks/bit, ack 3 cycles later -> rv_data = 0x55, rv_valid high until ack, all error flags 0.
- 8E1 (lcr[5:3] = 011), send 0xA3 with parity bit 1 -> parity_err = 1; repeat with bit 0 -> parity_err = 0. 8O1 with 0x00 and parity 1 -> no error.
- 6-tick low glitch on idle rx -> no rv_valid; an immediate valid 0x0F frame afterwards -> rv_data = 0x0F.
- 0x7E with stop bit held low -> frame_err = 1, brk = 0. All-zero frame, line low through stop -> brk = 1, frame_err = 1.
- Two frames 0x11 then 0x22 with no ack -> rv_data = 0x22, overrun = 1; ack -> all clear. Ack coincident with 2nd completion -> overrun stays 0.
- ideal_rx = 1 at data bit 4 (and separately rst at data bit 4) -> state IDLE, no rv_valid. Next full frame 0xC6 is received correctly.
